// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake, status and PS/2 line signals of the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       timeout;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ps2_clk_low;
   logic       ps2_data_low;

   modport master (
      output tx_data, tx_valid, ps2_clk, ps2_data,
      input  tx_ready, busy, done, ack_err, timeout, ps2_clk_low, ps2_data_low
   );

   modport slave (
      input  tx_data, tx_valid, ps2_clk, ps2_data,
      output tx_ready, busy, done, ack_err, timeout, ps2_clk_low, ps2_data_low
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit and request-to-send, shift a byte with odd
// parity and stop bit on device clock falls, then check the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int REQ_CYCLES     = 200,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic         clk,
   input  logic         rst_n,
   ps2_host_tx_if.slave bus
);
   localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 32'd1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 32'd1);
   localparam logic [PH_W-1:0]  INH_LAST = PH_W'(INHIBIT_CYCLES - 32'd1);
   localparam logic [PH_W-1:0]  REQ_LAST = PH_W'(REQ_CYCLES - 32'd1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1'b1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_REQ      = 3'd2,
      S_XFER     = 3'd3,
      S_ACK_CHK  = 3'd4,
      S_WAIT_REL = 3'd5,
      S_DONE     = 3'd6
   } state_e;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_e           state_q, state_d;
   logic [7:0]       sh_q, sh_d;
   logic             par_q, par_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             ack_flag_q, ack_flag_d;
   logic             tmo_flag_q, tmo_flag_d;
   logic             clk_meta_q, clk_sync_q, clk_prev_q;
   logic             dat_meta_q, dat_sync_q;
   logic             clk_low_q, clk_low_d, data_low_q, data_low_d;
   logic             ready_q, ready_d, busy_q, busy_d;
   logic             done_q, done_d, ack_err_q, ack_err_d, timeout_q, timeout_d;
   logic             fall_s;

   assign fall_s = clk_prev_q & ~clk_sync_q;

   // Two-flop synchronizers plus one history flop for clock fall detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= bus.ps2_clk;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= bus.ps2_data;
         dat_sync_q <= dat_meta_q;
      end
   end

   // Next state, datapath updates and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      par_d      = par_q;
      bitcnt_d   = bitcnt_q;
      ph_d       = ph_q;
      tmo_d      = tmo_q;
      ack_flag_d = ack_flag_q;
      tmo_flag_d = tmo_flag_q;
      data_low_d = data_low_q;
      case (state_q)
         S_IDLE: begin
            if (bus.tx_valid && ready_q) begin
               sh_d       = bus.tx_data;
               par_d      = odd_parity(bus.tx_data);
               bitcnt_d   = 4'd0;
               ph_d       = {PH_W{1'b0}};
               ack_flag_d = 1'b0;
               tmo_flag_d = 1'b0;
               state_d    = S_INHIBIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INHIBIT: begin
            if (ph_q == INH_LAST) begin
               ph_d    = {PH_W{1'b0}};
               state_d = S_REQ;
            end else begin
               ph_d = ph_q + PH_ONE;
            end
         end
         S_REQ: begin
            if (ph_q == REQ_LAST) begin
               ph_d    = {PH_W{1'b0}};
               tmo_d   = {TMO_W{1'b0}};
               state_d = S_XFER;
            end else begin
               ph_d = ph_q + PH_ONE;
            end
         end
         S_XFER: begin
            if (fall_s) begin
               tmo_d = {TMO_W{1'b0}};
               if (bitcnt_q == 4'd10) begin
                  state_d = S_ACK_CHK;
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q < 4'd8) begin
                     data_low_d = ~sh_q[bitcnt_q[2:0]];
                  end else if (bitcnt_q == 4'd8) begin
                     data_low_d = ~par_q;
                  end else begin
                     data_low_d = 1'b0;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_flag_d = 1'b1;
               ack_flag_d = 1'b0;
               state_d    = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
         end
         S_ACK_CHK: begin
            ack_flag_d = dat_sync_q;
            state_d    = S_WAIT_REL;
         end
         S_WAIT_REL: begin
            if (clk_sync_q && dat_sync_q) begin
               state_d = S_DONE;
            end else if (fall_s) begin
               tmo_d = {TMO_W{1'b0}};
            end else if (tmo_q == TMO_LAST) begin
               tmo_flag_d = 1'b1;
               ack_flag_d = 1'b0;
               state_d    = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Line drives follow the next state so they change on the same edge as the state.
      clk_low_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
      if (state_d == S_REQ) begin
         data_low_d = 1'b1;
      end else if (state_d != S_XFER) begin
         data_low_d = 1'b0;
      end else begin
         data_low_d = data_low_d;
      end
      ready_d   = (state_d == S_IDLE);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      ack_err_d = done_d & ack_flag_d;
      timeout_d = done_d & tmo_flag_d;
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sh_q       <= 8'h00;
         par_q      <= 1'b0;
         bitcnt_q   <= 4'd0;
         ph_q       <= {PH_W{1'b0}};
         tmo_q      <= {TMO_W{1'b0}};
         ack_flag_q <= 1'b0;
         tmo_flag_q <= 1'b0;
         clk_low_q  <= 1'b0;
         data_low_q <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         par_q      <= par_d;
         bitcnt_q   <= bitcnt_d;
         ph_q       <= ph_d;
         tmo_q      <= tmo_d;
         ack_flag_q <= ack_flag_d;
         tmo_flag_q <= tmo_flag_d;
         clk_low_q  <= clk_low_d;
         data_low_q <= data_low_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.tx_ready     = ready_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.ack_err      = ack_err_q;
   assign bus.timeout      = timeout_q;
   assign bus.ps2_clk_low  = clk_low_q;
   assign bus.ps2_data_low = data_low_q;
endmodule
